// File: rtl/microwave_pkg.sv
// microwave_pkg
// Shared definitions for the microwave front-panel input conditioning:
//   KEY_W                    - number of keypad digit lines
//   DEBOUNCE_CYCLES_DEFAULT  - default debounce depth in clock cycles
//   key_state_t              - keypad qualification FSM states
//   is_one_hot()             - true when exactly one bit of a key vector is set
package microwave_pkg;

  localparam int KEY_W                   = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_t;

  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
// Level debouncer for one raw contact, with optional two-flop synchronizer
// (enabled by defining KEYPAD_CONDITIONER_SYNC_EN).
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   raw    - raw contact input
//   level  - debounced level (registered)
//   rise   - strobe, high during the cycle whose clock edge will take level
//            from 0 to 1; the consumer registers it so that the output pulse
//            coincides with the level change
module debounce_bit
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic sample;

`ifdef KEYPAD_CONDITIONER_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clock) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[0], raw};
  end

  assign sample = sync_reg[1];
`else
  assign sample = raw;
`endif

  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             flip;

  // The counter holds how many consecutive differing samples have already
  // been seen, so the DEBOUNCE_CYCLES-th one flips the level on its own edge.
  assign flip = (sample != level_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (sample == level_reg) begin
      cnt_reg   <= '0;
    end else if (flip) begin
      cnt_reg   <= '0;
      level_reg <= sample;
    end else begin
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign level = level_reg;
  assign rise  = flip & sample;

endmodule

// File: rtl/keypad_conditioner.sv
// keypad_conditioner
// Conditions the raw microwave front panel: qualifies keypad presses into
// single one-hot digit pulses (rejecting multi-key presses), debounces the
// start/clear/stop buttons into active-low single-cycle pulses and debounces
// the door switch. Define KEYPAD_CONDITIONER_SYNC_EN to put a two-flop
// synchronizer on every raw input (adds two cycles of latency).
// Ports:
//   clock, reset                  - system clock; synchronous active-high reset
//   keypad_raw[9:0]               - raw digit contacts, bit i = digit i
//   start_raw/clear_raw/stop_raw  - raw button contacts, active-high
//   door_raw                      - raw door switch, 1 = closed
//   keypad[9:0]                   - one-cycle one-hot digit pulse
//   startn/clearn/stopn           - one-cycle active-low button pulses
//   door_closed                   - debounced door level
//   multi_key_err                 - one-cycle pulse on a rejected multi-key press
module keypad_conditioner
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] keypad_raw,
  input  logic             start_raw,
  input  logic             clear_raw,
  input  logic             stop_raw,
  input  logic             door_raw,
  output logic [KEY_W-1:0] keypad,
  output logic             startn,
  output logic             clearn,
  output logic             stopn,
  output logic             door_closed,
  output logic             multi_key_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // ---------------- buttons and door ----------------
  // Index map: 0 = start, 1 = clear, 2 = stop, 3 = door.
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;

  assign btn_raw = {door_raw, stop_raw, clear_raw, start_raw};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clock (clock),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi]),
        .rise  (btn_rise[gi])
      );
    end
  endgenerate

  logic start_pulse, clear_pulse, stop_pulse;
  logic startn_reg, clearn_reg, stopn_reg;

  // clear > stop > start on coincident edges; losers are simply dropped.
  // start is also ignored while the debounced door is open.
  assign clear_pulse = btn_rise[1];
  assign stop_pulse  = btn_rise[2] & ~btn_rise[1];
  assign start_pulse = btn_rise[0] & ~btn_rise[1] & ~btn_rise[2] & btn_level[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      startn_reg <= 1'b1;
      clearn_reg <= 1'b1;
      stopn_reg  <= 1'b1;
    end else begin
      startn_reg <= ~start_pulse;
      clearn_reg <= ~clear_pulse;
      stopn_reg  <= ~stop_pulse;
    end
  end

  assign startn      = startn_reg;
  assign clearn      = clearn_reg;
  assign stopn       = stopn_reg;
  assign door_closed = btn_level[3];

  // ---------------- keypad ----------------
  logic [KEY_W-1:0] key_sample;

`ifdef KEYPAD_CONDITIONER_SYNC_EN
  logic [KEY_W-1:0] key_meta_reg, key_sync_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta_reg <= '0;
      key_sync_reg <= '0;
    end else begin
      key_meta_reg <= keypad_raw;
      key_sync_reg <= key_meta_reg;
    end
  end

  assign key_sample = key_sync_reg;
`else
  assign key_sample = keypad_raw;
`endif

  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [KEY_W-1:0] capture_reg, capture_next;
  logic [KEY_W-1:0] keypad_reg, keypad_next;
  logic             err_reg, err_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      capture_reg <= '0;
      keypad_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      capture_reg <= capture_next;
      keypad_reg  <= keypad_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    capture_next = capture_reg;
    keypad_next  = '0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_sample != '0) begin
          capture_next = key_sample;
          cnt_next     = CNT_W'(1);
          state_next   = QUALIFY;
        end
      end
      QUALIFY: begin
        if (key_sample == '0) begin
          state_next = IDLE;
        end else if (key_sample == capture_reg) begin
          // Counter reaches DEBOUNCE_CYCLES on this edge: accept and pulse.
          if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_next   = CNT_W'(DEBOUNCE_CYCLES);
            state_next = HELD;
            if (is_one_hot(capture_reg)) keypad_next = capture_reg;
            else                         err_next    = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          capture_next = key_sample;
          cnt_next     = CNT_W'(1);
        end
      end
      HELD: begin
        if (key_sample == '0) begin
          cnt_next   = CNT_W'(1);
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // A bounce back to non-zero returns to HELD without a new pulse.
        if (key_sample != '0) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign keypad        = keypad_reg;
  assign multi_key_err = err_reg;

endmodule

// File: tb/tb_keypad_conditioner.sv
// tb_keypad_conditioner
// Directed bench for keypad_conditioner with DEBOUNCE_CYCLES=4. Expected
// pulse latency is 4 edges, or 6 when KEYPAD_CONDITIONER_SYNC_EN is defined.
module tb_keypad_conditioner;

  localparam int D = 4;
`ifdef KEYPAD_CONDITIONER_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad_raw;
  logic       start_raw, clear_raw, stop_raw, door_raw;
  logic [9:0] keypad;
  logic       startn, clearn, stopn, door_closed, multi_key_err;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .keypad_raw    (keypad_raw),
    .start_raw     (start_raw),
    .clear_raw     (clear_raw),
    .stop_raw      (stop_raw),
    .door_raw      (door_raw),
    .keypad        (keypad),
    .startn        (startn),
    .clearn        (clearn),
    .stopn         (stopn),
    .door_closed   (door_closed),
    .multi_key_err (multi_key_err)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_keypad"}, 16'(keypad), 16'h000);
    check({tag, "_startn"}, 16'(startn), 16'h1);
    check({tag, "_clearn"}, 16'(clearn), 16'h1);
    check({tag, "_stopn"},  16'(stopn),  16'h1);
    check({tag, "_door"},   16'(door_closed), 16'h0);
    check({tag, "_err"},    16'(multi_key_err), 16'h0);
  endtask

  initial begin
    reset = 1'b1; keypad_raw = '0;
    start_raw = 1'b0; clear_raw = 1'b0; stop_raw = 1'b0; door_raw = 1'b0;
    step(); step();
    check_reset_state("reset");
    reset = 1'b0;

    // Single key 0x002 held 20 cycles: exactly one pulse at LAT.
    keypad_raw = 10'h002;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("single_key_c%0d", i), 16'(keypad), (i == LAT) ? 16'h002 : 16'h000);
    end
    keypad_raw = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("single_rel_c%0d", i), 16'(keypad), 16'h000);
    end

    // Bouncing key: 2 high / 2 low for 12 cycles, then steady.
    for (int i = 0; i < 12; i++) begin
      keypad_raw = ((i / 2) % 2 == 0) ? 10'h002 : 10'h000;
      step();
      check($sformatf("bounce_c%0d", i), 16'(keypad), 16'h000);
    end
    keypad_raw = 10'h002;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("bounce_steady_c%0d", i), 16'(keypad), (i == LAT) ? 16'h002 : 16'h000);
    end
    keypad_raw = '0;
    repeat (12) step();

    // Two keys 0x006 held: no digit pulse, one error pulse at LAT.
    keypad_raw = 10'h006;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("multi_key_c%0d", i), 16'(keypad), 16'h000);
      check($sformatf("multi_err_c%0d", i), 16'(multi_key_err), (i == LAT) ? 16'h1 : 16'h0);
    end
    keypad_raw = '0;
    repeat (12) step();

    // Close the door.
    door_raw = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      check($sformatf("door_close_c%0d", i), 16'(door_closed), (i >= LAT) ? 16'h1 : 16'h0);
    end

    // start + clear together: clear wins.
    start_raw = 1'b1; clear_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("sc_clearn_c%0d", i), 16'(clearn), (i == LAT) ? 16'h0 : 16'h1);
      check($sformatf("sc_startn_c%0d", i), 16'(startn), 16'h1);
    end
    start_raw = 1'b0; clear_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("sc_rel_c%0d", i), 16'({startn, clearn, stopn}), 16'h7);
    end

    // stop + start together: stop wins.
    start_raw = 1'b1; stop_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("ss_stopn_c%0d", i), 16'(stopn), (i == LAT) ? 16'h0 : 16'h1);
      check($sformatf("ss_startn_c%0d", i), 16'(startn), 16'h1);
    end
    start_raw = 1'b0; stop_raw = 1'b0;
    repeat (10) step();

    // Lone start with door closed: startn pulses.
    start_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("start_c%0d", i), 16'(startn), (i == LAT) ? 16'h0 : 16'h1);
    end
    start_raw = 1'b0;
    repeat (10) step();

    // Door open: start is dropped; door then closes after LAT edges.
    door_raw = 1'b0;
    repeat (LAT + 2) step();
    check("door_open", 16'(door_closed), 16'h0);
    start_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("door_open_startn_c%0d", i), 16'(startn), 16'h1);
    end
    door_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("door_rise_c%0d", i), 16'(door_closed), (i >= LAT) ? 16'h1 : 16'h0);
      check($sformatf("door_rise_startn_c%0d", i), 16'(startn), 16'h1);
    end
    start_raw = 1'b0;
    repeat (10) step();

    // Reset during qualification of 0x001, key still held afterwards.
    keypad_raw = 10'h001;
    repeat (3) step();
    reset = 1'b1;
    step();
    check_reset_state("mid_reset");
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("requal_c%0d", i), 16'(keypad), (i == LAT) ? 16'h001 : 16'h000);
    end
    keypad_raw = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
